// File: rtl/reconciled_key_streamer.sv
// Records per-frame EV results, then streams words of passing frames from the reconciled-key BRAM to the PA FIFO.
// Read-to-FIFO latency RD_LATENCY+2 cycles; pa_full stalls reads via occupancy credits, nothing is dropped.
module reconciled_key_streamer #(
  parameter int FRAME_WORDS = 256,
  parameter int NUM_FRAMES  = 64,
  parameter int RD_LATENCY  = 2,
  parameter int BUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done,
  input  logic        frame_fail,
  input  logic        start_stream,
  input  logic        addr_index,
  output logic        busy,
  output logic        finish_stream,
  output logic [6:0]  passed_frame_cnt,
  output logic        rkey_clkb,
  output logic        rkey_enb,
  output logic        rkey_web,
  output logic [14:0] rkey_addrb,
  input  logic [63:0] rkey_doutb,
  output logic        pa_wr_clk,
  output logic        pa_wr_en,
  output logic [63:0] pa_wr_din,
  input  logic        pa_full
);

  localparam int AW = 14;
  localparam int WW = $clog2(FRAME_WORDS);
  localparam int FW = $clog2(NUM_FRAMES) + 1;
  localparam int RW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(BUF_DEPTH + RD_LATENCY + 3);
  localparam int SR = RD_LATENCY + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [NUM_FRAMES-1:0] bitmap_q;
  logic [RW-1:0]       rec_ptr_q;
  logic [FW-1:0]       frame_q;
  logic [WW-1:0]       word_q;
  logic [6:0]          cnt_q;
  logic                busy_q;
  logic                finish_q;
  logic [6:0]          passed_q;

  logic [14:0]         addr_q;
  logic [SR-1:0]       vld_q;
  logic [63:0]         buf_q [BUF_DEPTH];
  logic [PW-1:0]       wptr_q;
  logic [PW-1:0]       rptr_q;
  logic [OW-1:0]       occ_q;
  logic [OW-1:0]       occ_d;
  logic                wr_en_q;
  logic [63:0]         wr_din_q;

  logic [CW-1:0]       inflight;
  logic                push;
  logic                pop;
  logic                issue;
  logic [AW-1:0]       rd_addr_lo;

  // vld_q[SR-1] high means doutb carries the word addressed SR-1 cycles earlier.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SR; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
    push       = vld_q[SR-1];
    pop        = (occ_q != '0) && !pa_full;
    // A pop this cycle frees a slot, which keeps full rate at steady state.
    issue      = (state_q == S_READ) &&
                 ((CW'(occ_q) + inflight) < (CW'(BUF_DEPTH) + CW'(pop)));
    rd_addr_lo = (AW'(frame_q) << WW) | AW'(word_q);
    occ_d      = occ_q + OW'(push) - OW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bitmap_q  <= '0;
      rec_ptr_q <= '0;
      frame_q   <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      passed_q  <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_done) begin
            bitmap_q[rec_ptr_q] <= frame_fail;
            if (rec_ptr_q != RW'(NUM_FRAMES - 1)) begin
              rec_ptr_q <= rec_ptr_q + 1'b1;
            end
          end
          if (start_stream) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            frame_q <= '0;
            cnt_q   <= '0;
          end
        end
        S_SCAN: begin
          if (frame_q == FW'(NUM_FRAMES)) begin
            state_q <= S_DRAIN;
          end else if (bitmap_q[frame_q[RW-1:0]]) begin
            frame_q <= frame_q + 1'b1;
          end else begin
            word_q  <= '0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            word_q <= word_q + 1'b1;
            if (word_q == WW'(FRAME_WORDS - 1)) begin
              frame_q <= frame_q + 1'b1;
              state_q <= S_SCAN;
            end
          end
        end
        S_DRAIN: begin
          if (inflight == '0 && occ_q == '0) begin
            finish_q <= 1'b1;
            passed_q <= cnt_q;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q    <= 1'b0;
          bitmap_q  <= '0;
          rec_ptr_q <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      occ_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_din_q <= '0;
    end else begin
      vld_q <= {vld_q[SR-2:0], issue};
      if (issue) begin
        addr_q <= {addr_index, rd_addr_lo};
      end
      if (push) begin
        wptr_q <= (wptr_q == PW'(BUF_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q   <= (rptr_q == PW'(BUF_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        wr_din_q <= buf_q[rptr_q];
      end
      occ_q   <= occ_d;
      wr_en_q <= pop;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wptr_q] <= rkey_doutb;
    end
  end

  assign busy             = busy_q;
  assign finish_stream    = finish_q;
  assign passed_frame_cnt = passed_q;
  assign rkey_clkb        = clk;
  assign rkey_enb         = 1'b1;
  assign rkey_web         = 1'b0;
  assign rkey_addrb       = addr_q;
  assign pa_wr_clk        = clk;
  assign pa_wr_en         = wr_en_q;
  assign pa_wr_din        = wr_din_q;

endmodule

// File: tb/tb_reconciled_key_streamer.sv
// Directed bench for reconciled_key_streamer: BRAM model with 2-cycle read latency and an ordered write scoreboard.
module tb_reconciled_key_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_done;
  logic        frame_fail;
  logic        start_stream;
  logic        addr_index;
  logic        busy;
  logic        finish_stream;
  logic [6:0]  passed_frame_cnt;
  logic        rkey_clkb;
  logic        rkey_enb;
  logic        rkey_web;
  logic [14:0] rkey_addrb;
  logic [63:0] rkey_doutb;
  logic        pa_wr_clk;
  logic        pa_wr_en;
  logic [63:0] pa_wr_din;
  logic        pa_full;

  always #5 clk = ~clk;

  reconciled_key_streamer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_done       (frame_done),
    .frame_fail       (frame_fail),
    .start_stream     (start_stream),
    .addr_index       (addr_index),
    .busy             (busy),
    .finish_stream    (finish_stream),
    .passed_frame_cnt (passed_frame_cnt),
    .rkey_clkb        (rkey_clkb),
    .rkey_enb         (rkey_enb),
    .rkey_web         (rkey_web),
    .rkey_addrb       (rkey_addrb),
    .rkey_doutb       (rkey_doutb),
    .pa_wr_clk        (pa_wr_clk),
    .pa_wr_en         (pa_wr_en),
    .pa_wr_din        (pa_wr_din),
    .pa_full          (pa_full)
  );

  function automatic logic [63:0] bram_word(input logic [14:0] a);
    return {16'hB0B0, 1'b0, a, ~{17'd0, a}};
  endfunction

  // Two register stages: address sampled, then data registered.
  logic [14:0] bram_a1;
  always @(posedge clk) begin
    bram_a1    <= rkey_addrb;
    rkey_doutb <= bram_word(bram_a1);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic [14:0] exp_q[$];
  logic [14:0] exp_a;
  logic [14:0] prev_addr = '0;
  logic [63:0] fail_frames = '0;
  logic        full_last = 1'b0;
  logic        full_en = 1'b0;
  int wr_cnt, data_err, fin_cnt, bad_rd, full_viol, occ_max, full_cyc;

  always @(negedge clk) begin
    if (pa_wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) data_err++;
      else begin
        exp_a = exp_q.pop_front();
        if (pa_wr_din !== bram_word(exp_a)) data_err++;
      end
      if (full_last) full_viol++;
    end
    full_last = pa_full;
    if (pa_full) full_cyc++;
    if (finish_stream === 1'b1) fin_cnt++;
    if (rkey_addrb !== prev_addr && fail_frames[rkey_addrb[13:8]]) bad_rd++;
    prev_addr = rkey_addrb;
    if (int'(dut.occ_q) > occ_max) occ_max = int'(dut.occ_q);
  end

  // pa_full high for cycles 30..49 of every 50 while enabled.
  initial begin
    int tog;
    tog = 0;
    pa_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (full_en) begin
        tog++;
        pa_full = (tog % 50) >= 30;
      end else begin
        tog = 0;
        pa_full = 1'b0;
      end
    end
  end

  task automatic clear_tallies(input logic [63:0] pass, input logic aidx);
    exp_q.delete();
    for (int f = 0; f < 64; f++)
      if (pass[f])
        for (int w = 0; w < 256; w++) exp_q.push_back({aidx, 6'(f), 8'(w)});
    fail_frames = ~pass;
    wr_cnt = 0; data_err = 0; fin_cnt = 0; bad_rd = 0;
    full_viol = 0; occ_max = 0; full_cyc = 0;
  endtask

  task automatic record(input logic [63:0] fails, input int n);
    for (int i = 0; i < n; i++) begin
      frame_done = 1'b1;
      frame_fail = fails[i];
      @(posedge clk);
      #1;
    end
    frame_done = 1'b0;
    frame_fail = 1'b0;
  endtask

  task automatic run_stream(input string tag, input logic [63:0] pass, input logic aidx,
                            input int exp_cnt, input int budget, output int lat);
    clear_tallies(pass, aidx);
    addr_index   = aidx;
    start_stream = 1'b1;
    @(posedge clk);
    #1;
    start_stream = 1'b0;
    lat = 0;
    chk({tag, "_busy_after_start"}, busy, 1);
    while (finish_stream !== 1'b1 && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
      start_stream = (lat == 10);
    end
    start_stream = 1'b0;
    chk({tag, "_finish_seen"}, finish_stream, 1);
    chk({tag, "_passed_cnt"}, passed_frame_cnt, exp_cnt);
    @(posedge clk);
    #1;
    chk({tag, "_finish_one_cycle"}, finish_stream, 0);
    chk({tag, "_busy_cleared"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_words"}, wr_cnt, exp_cnt * 256);
    chk({tag, "_data_errors"}, data_err, 0);
    chk({tag, "_missing_words"}, exp_q.size(), 0);
    chk({tag, "_finish_pulses"}, fin_cnt, 1);
    chk({tag, "_failed_frame_reads"}, bad_rd, 0);
    chk({tag, "_occ_le_4"}, occ_max <= 4, 1);
  endtask

  initial begin
    int lat;
    logic [63:0] m;
    rst_n = 1'b0; frame_done = 1'b0; frame_fail = 1'b0;
    start_stream = 1'b0; addr_index = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish_stream, 0);
    chk("rst_wr_en", pa_wr_en, 0);
    chk("rst_addrb", rkey_addrb, 0);
    chk("rst_wr_din_lo", pa_wr_din[31:0], 0);
    chk("rst_passed", passed_frame_cnt, 0);
    chk("enb_const", rkey_enb, 1);
    chk("web_const", rkey_web, 0);

    // All frames pass, lower half of BRAM.
    record(64'd0, 64);
    run_stream("s1", ~64'd0, 1'b0, 64, 17000, lat);
    chk("s1_latency_bound", lat <= 16460, 1);

    // Frame 3 fails; frame 63 fails via an extra pulse overwriting the saturated last bit.
    m = 64'd0;
    m[3] = 1'b1;
    record(m, 64);
    record(64'd1, 1);
    run_stream("s2", ~(m | (64'd1 << 63)), 1'b0, 62, 17000, lat);

    // Only frame 0 passes, upper half of BRAM.
    record(~64'd1, 64);
    run_stream("s3", 64'd1, 1'b1, 1, 2000, lat);

    // Frames 0 and 1 pass under periodic backpressure.
    record(~64'd3, 64);
    full_en = 1'b1;
    run_stream("s4", 64'd3, 1'b0, 2, 6000, lat);
    chk("s4_write_while_full", full_viol, 0);
    chk("s4_backpressure_applied", full_cyc > 0, 1);
    full_en = 1'b0;

    // Every frame fails.
    record(~64'd0, 64);
    run_stream("s5", 64'd0, 1'b0, 0, 200, lat);
    chk("s5_finish_latency", lat <= 67, 1);

    // Reset after 100 words, with frame 10 marked failed beforehand.
    m = 64'd0;
    m[10] = 1'b1;
    record(m, 64);
    clear_tallies(~m, 1'b0);
    start_stream = 1'b1;
    @(posedge clk);
    #1;
    start_stream = 1'b0;
    for (int c = 0; c < 2000 && wr_cnt < 100; c++) @(posedge clk);
    chk("s6_reached_100_words", wr_cnt >= 100, 1);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_wr_en_after_rst", pa_wr_en, 0);
    chk("s6_busy_after_rst", busy, 0);
    chk("s6_addrb_after_rst", rkey_addrb, 0);
    chk("s6_passed_after_rst", passed_frame_cnt, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("s6_no_write_after_rst", pa_wr_en, 0);
    run_stream("s6b", ~64'd0, 1'b0, 64, 17000, lat);
    chk("s6b_latency_bound", lat <= 16460, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
